// File: rtl/pc_stack_counter.sv
// pc_stack_counter: parametrised program counter with a hardware
// call/return stack, relative branch, absolute jump and pipeline stall.
// Optional feature macro: PC_PREV_EN adds pc_prev (address of the
// instruction just retired).
module pc_stack_counter #(
    parameter int            AW        = 8,
    parameter int            STEP      = 1,
    parameter logic [AW-1:0] RESET_VEC = '0,
    parameter int            DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       inc,
    input  logic                       jump,
    input  logic                       branch,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       err_clr,
    input  logic [AW-1:0]              target,
    input  logic [AW-1:0]              offset,
    output logic [AW-1:0]              pc,
    output logic [AW-1:0]              pc_next,
    output logic [$clog2(DEPTH):0]     depth,
`ifdef PC_PREV_EN
    output logic [AW-1:0]              pc_prev,
`endif
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       stack_err
);

    localparam int            PW     = $clog2(DEPTH);
    localparam int            DW     = PW + 1;
    localparam logic [AW-1:0] STEP_V = AW'(STEP);
    localparam logic [DW-1:0] FULL_V = DW'(DEPTH);

    logic [AW-1:0] pc_q;
    logic [DW-1:0] depth_q;
    logic          err_q;
    logic [AW-1:0] stack [DEPTH];

    logic [AW-1:0] pc_seq;
    logic [PW-1:0] top_idx;
    logic [PW-1:0] push_idx;
    logic [DW-1:0] depth_nxt;
    logic          push;
    logic          err_set;

    // Sequential successor; shared by inc, ret-underflow and the pushed
    // return address. Wraps silently modulo 2^AW.
    assign pc_seq   = pc_q + STEP_V;
    // When full, depth's low bits are zero and top_idx wraps to DEPTH-1.
    assign top_idx  = depth_q[PW-1:0] - PW'(1);
    assign push_idx = depth_q[PW-1:0];

    assign stack_full  = (depth_q == FULL_V);
    assign stack_empty = (depth_q == '0);

    // Next-state decode: ret > call > jump > branch > inc > hold, and
    // everything frozen under stall.
    always_comb begin
        pc_next   = pc_q;
        depth_nxt = depth_q;
        push      = 1'b0;
        err_set   = 1'b0;
        if (!stall) begin
            if (ret) begin
                if (stack_empty) begin
                    pc_next = pc_seq;
                    err_set = 1'b1;
                end else begin
                    pc_next   = stack[top_idx];
                    depth_nxt = depth_q - DW'(1);
                end
            end else if (call) begin
                pc_next = target;
                if (stack_full) begin
                    err_set = 1'b1;
                end else begin
                    push      = 1'b1;
                    depth_nxt = depth_q + DW'(1);
                end
            end else if (jump) begin
                pc_next = target;
            end else if (branch) begin
                pc_next = pc_q + offset;
            end else if (inc) begin
                pc_next = pc_seq;
            end
        end
    end

    // PC, depth and sticky error register; a new error beats err_clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_VEC;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_next;
            depth_q <= depth_nxt;
            err_q   <= err_set | (err_q & ~err_clr);
        end
    end

    // Return-address storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push) stack[push_idx] <= pc_seq;
    end

`ifdef PC_PREV_EN
    logic [AW-1:0] prev_q;

    // Captures the PC being retired on every non-stalled edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      prev_q <= RESET_VEC;
        else if (!stall) prev_q <= pc_q;
    end

    assign pc_prev = prev_q;
`endif

    assign pc        = pc_q;
    assign depth     = depth_q;
    assign stack_err = err_q;

endmodule

// File: tb/tb_pc_stack_counter.sv
// tb_pc_stack_counter: directed test-plan sequences plus randomized
// traffic, checked against a queue-based behavioural model.
module tb_pc_stack_counter;

    localparam int         AW    = 8;
    localparam int         DEPTH = 4;
    localparam logic [7:0] RV    = 8'h10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       stall = 1'b0, inc = 1'b0, jump = 1'b0, branch = 1'b0;
    logic       call = 1'b0, ret = 1'b0, err_clr = 1'b0;
    logic [7:0] target = '0, offset = '0;
    logic [7:0] pc, pc_next;
    logic [2:0] depth;
    logic       stack_full, stack_empty, stack_err;
`ifdef PC_PREV_EN
    logic [7:0] pc_prev;
`endif

    pc_stack_counter #(.AW(AW), .STEP(1), .RESET_VEC(RV), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stall(stall), .inc(inc), .jump(jump),
        .branch(branch), .call(call), .ret(ret), .err_clr(err_clr),
        .target(target), .offset(offset), .pc(pc), .pc_next(pc_next),
        .depth(depth),
`ifdef PC_PREV_EN
        .pc_prev(pc_prev),
`endif
        .stack_full(stack_full), .stack_empty(stack_empty),
        .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: return stack as a queue, PC as a plain byte.
    logic [7:0] stk[$];
    logic [7:0] m_pc;
    logic       m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        stk.delete();
        m_pc  = RV;
        m_err = 1'b0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".pc"},    pc, m_pc);
        chk({tag, ".depth"}, depth, stk.size());
        chk({tag, ".full"},  stack_full, stk.size() == DEPTH);
        chk({tag, ".empty"}, stack_empty, stk.size() == 0);
        chk({tag, ".err"},   stack_err, m_err);
    endtask

    // One cycle: called at a falling edge, returns at the next falling edge.
    task automatic cyc(input logic s, input logic i, input logic j, input logic b,
                       input logic c, input logic r, input logic ec,
                       input logic [7:0] t, input logic [7:0] o);
        logic [7:0] np;
        logic       eset;
        bit         pop, psh;
        np = m_pc; eset = 1'b0; pop = 0; psh = 0;
        stall = s; inc = i; jump = j; branch = b; call = c; ret = r;
        err_clr = ec; target = t; offset = o;
        #1;
        if (!s) begin
            if (r) begin
                if (stk.size() == 0) begin np = m_pc + 8'd1; eset = 1'b1; end
                else begin np = stk[$]; pop = 1; end
            end else if (c) begin
                np = t;
                if (stk.size() == DEPTH) eset = 1'b1;
                else psh = 1;
            end else if (j) np = t;
            else if (b) np = m_pc + o;
            else if (i) np = m_pc + 8'd1;
        end
        chk("pc_next", pc_next, np);
        @(posedge clk); #1;
        if (pop) void'(stk.pop_back());
        if (psh) stk.push_back(m_pc + 8'd1);
        m_pc  = np;
        m_err = eset | (m_err & ~ec);
        chk_state("cyc");
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        #12;
        chk_state("reset");
        chk("reset.pc_const", pc, 8'h10);
        @(negedge clk);
        reset = 1'b1;

        // inc x3 from RESET_VEC
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
            chk("tp_inc", pc, 8'h11 + k);
        end

        // wrap on inc, negative branch wrap
        cyc(0, 0, 1, 0, 0, 0, 0, 8'hFF, 8'h00);
        cyc(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        chk("tp_wrap", pc, 8'h00);
        cyc(0, 0, 0, 1, 0, 0, 0, 8'h00, 8'hFE);
        chk("tp_branch_neg", pc, 8'hFE);

        // call / ret round trip
        cyc(0, 0, 1, 0, 0, 0, 0, 8'h20, 8'h00);
        cyc(0, 0, 0, 0, 1, 0, 0, 8'h40, 8'h00);
        chk("tp_call_pc", pc, 8'h40);
        chk("tp_call_depth", depth, 3'd1);
        cyc(0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
        chk("tp_ret_pc", pc, 8'h21);
        chk("tp_ret_depth", depth, 3'd0);

        // overflow then underflow
        cyc(0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 1, 0, 0, 8'h10, 8'h00);
        chk("tp_ovf_full", stack_full, 1'b1);
        chk("tp_ovf_err", stack_err, 1'b1);
        chk("tp_ovf_depth", depth, 3'd4);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
            chk("tp_pop", pc, (k == 3) ? 8'h01 : 8'h11);
        end
        cyc(0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
        chk("tp_udf_pc", pc, 8'h02);
        chk("tp_udf_err", stack_err, 1'b1);
        cyc(0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
        chk("tp_err_clr", stack_err, 1'b0);

        // stall with jump
        cyc(1, 0, 1, 0, 0, 0, 0, 8'h55, 8'h00);
        chk("tp_stall_pc", pc, 8'h02);
        cyc(0, 0, 1, 0, 0, 0, 0, 8'h55, 8'h00);
        chk("tp_unstall_pc", pc, 8'h55);

        // ret beats jump and inc
        cyc(0, 0, 1, 0, 0, 0, 0, 8'h32, 8'h00);
        cyc(0, 0, 0, 0, 1, 0, 0, 8'h77, 8'h00);
        cyc(0, 1, 1, 0, 0, 1, 0, 8'h88, 8'h00);
        chk("tp_prio_pc", pc, 8'h33);
        chk("tp_prio_depth", depth, 3'd0);

        // async reset mid-cycle
        cyc(0, 0, 0, 0, 1, 0, 0, 8'hA0, 8'h00);
        #2 reset = 1'b0;
        #1;
        chk("tp_async_pc", pc, 8'h10);
        chk("tp_async_depth", depth, 3'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [7:0] sel;
            sel = 8'($urandom_range(0, 99));
            cyc(sel < 12,
                1'($urandom_range(0, 1)),
                $urandom_range(0, 99) < 15,
                $urandom_range(0, 99) < 20,
                $urandom_range(0, 99) < 25,
                $urandom_range(0, 99) < 25,
                $urandom_range(0, 99) < 10,
                8'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
